// File: rtl/rob_pkg.sv
// Shared types and constants for the parametrised reorder buffer.
// Entry layout, instruction classes and the RV32 encodings the commit path relies on.
package rob_pkg;

   typedef enum logic [2:0] {
      ROB_ALU    = 3'd0,
      ROB_LOAD   = 3'd1,
      ROB_STORE  = 3'd2,
      ROB_BRANCH = 3'd3,
      ROB_JAL    = 3'd4,
      ROB_HALT   = 3'd5
   } rob_type_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [2:0] F3_SB     = 3'b000;
   localparam logic [2:0] F3_SH     = 3'b001;
   localparam logic [2:0] F3_SW     = 3'b010;

   typedef struct packed {
      rob_type_t   rtype;
      logic [4:0]  dest;
      logic [31:0] pc;
      logic [31:0] value;
      logic [31:0] addr;
      logic [31:0] target;
      logic        ready;
      logic        mispred;
   } rob_entry_t;

   function automatic logic writes_rd(input rob_type_t t);
      return (t == ROB_ALU) || (t == ROB_LOAD) || (t == ROB_JAL);
   endfunction

   function automatic logic is_ctrl(input rob_type_t t);
      return (t == ROB_BRANCH) || (t == ROB_JAL);
   endfunction

endpackage

// File: rtl/rob_param_if.sv
// Issue, execution and commit-side bundle of the reorder buffer.
// The master side is the core pipeline; the slave side is the ROB itself.
interface rob_param_if #(
   parameter int DEPTH  = 16,
   parameter int IDX_W  = $clog2(DEPTH),
   parameter int NUM_WB = 2,
   parameter int NUM_RD = 4
);
   import rob_pkg::*;

   logic                     alloc_valid;
   logic                     alloc_ready;
   rob_type_t                alloc_type;
   logic [4:0]               alloc_dest;
   logic [31:0]              alloc_pc;
   logic [IDX_W-1:0]         alloc_idx;
   logic [NUM_WB-1:0]        wb_valid;
   logic [NUM_WB*IDX_W-1:0]  wb_idx;
   logic [NUM_WB*32-1:0]     wb_data;
   logic [NUM_WB-1:0]        wb_mispred;
   logic [NUM_WB*32-1:0]     wb_target;
   logic                     st_valid;
   logic [IDX_W-1:0]         st_idx;
   logic [31:0]              st_addr;
   logic [31:0]              st_data;
   logic [NUM_RD*IDX_W-1:0]  rd_idx;
   logic [NUM_RD*32-1:0]     rd_data;
   logic [NUM_RD-1:0]        rd_ready;
   logic                     commit_valid;
   logic [IDX_W-1:0]         commit_idx;
   logic                     reg_we;
   logic [4:0]               reg_idx;
   logic [31:0]              reg_data;
   logic                     mem_we;
   logic [31:0]              mem_addr;
   logic [31:0]              mem_data;
   logic [2:0]               mem_size;
   logic                     redirect_valid;
   logic [31:0]              redirect_pc;
   logic                     halt;
   logic [IDX_W:0]           count;
   logic                     empty;
   logic                     full;

   modport master (
      output alloc_valid, alloc_type, alloc_dest, alloc_pc,
      output wb_valid, wb_idx, wb_data, wb_mispred, wb_target,
      output st_valid, st_idx, st_addr, st_data, rd_idx,
      input  alloc_ready, alloc_idx, rd_data, rd_ready,
      input  commit_valid, commit_idx, reg_we, reg_idx, reg_data,
      input  mem_we, mem_addr, mem_data, mem_size,
      input  redirect_valid, redirect_pc, halt, count, empty, full
   );

   modport slave (
      input  alloc_valid, alloc_type, alloc_dest, alloc_pc,
      input  wb_valid, wb_idx, wb_data, wb_mispred, wb_target,
      input  st_valid, st_idx, st_addr, st_data, rd_idx,
      output alloc_ready, alloc_idx, rd_data, rd_ready,
      output commit_valid, commit_idx, reg_we, reg_idx, reg_data,
      output mem_we, mem_addr, mem_data, mem_size,
      output redirect_valid, redirect_pc, halt, count, empty, full
   );
endinterface

// File: rtl/rob_wb_merge.sv
// Priority merge of the result strobes aimed at one ROB index.
// Later ports override earlier ones; the store port ranks above every CDB port.
module rob_wb_merge #(
   parameter int IDX_W  = 4,
   parameter int NUM_WB = 2
) (
   input  logic [IDX_W-1:0]        q_idx,
   input  logic [NUM_WB-1:0]       wb_valid,
   input  logic [NUM_WB*IDX_W-1:0] wb_idx,
   input  logic [NUM_WB*32-1:0]    wb_data,
   input  logic [NUM_WB-1:0]       wb_mispred,
   input  logic [NUM_WB*32-1:0]    wb_target,
   input  logic                    st_valid,
   input  logic [IDX_W-1:0]        st_idx,
   input  logic [31:0]             st_addr,
   input  logic [31:0]             st_data,
   output logic                    hit,
   output logic                    is_st,
   output logic [31:0]             value,
   output logic                    mispred,
   output logic [31:0]             target,
   output logic [31:0]             addr
);
   logic [NUM_WB:0] match_s;

   // Per-port index match against the queried entry
   always_comb begin
      match_s = '0;
      for (int p = 0; p < NUM_WB; p++) begin
         match_s[p] = wb_valid[p] && (wb_idx[p*IDX_W +: IDX_W] == q_idx);
      end
      match_s[NUM_WB] = st_valid && (st_idx == q_idx);
   end

   // Highest-numbered matching port supplies the merged payload
   always_comb begin
      hit     = 1'b0;
      value   = 32'h0;
      mispred = 1'b0;
      target  = 32'h0;
      for (int p = 0; p < NUM_WB; p++) begin
         hit     = hit | match_s[p];
         value   = match_s[p] ? wb_data[p*32 +: 32]   : value;
         mispred = match_s[p] ? wb_mispred[p]         : mispred;
         target  = match_s[p] ? wb_target[p*32 +: 32] : target;
      end
      is_st   = match_s[NUM_WB];
      hit     = hit | is_st;
      value   = is_st ? st_data : value;
      mispred = is_st ? 1'b0 : mispred;
      addr    = is_st ? st_addr : 32'h0;
   end
endmodule

// File: rtl/rob_param.sv
// In-order-commit reorder buffer: N writeback ports, valid/ready allocation,
// mispredict flush and one registered commit per cycle.
module rob_param
   import rob_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int IDX_W  = $clog2(DEPTH),
   parameter int NUM_WB = 2,
   parameter int NUM_RD = 4
) (
   input logic        clk,
   input logic        rst_n,
   rob_param_if.slave bus
);
   localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

   rob_entry_t        entries_r [DEPTH];
   logic [IDX_W:0]    head_r, tail_r, count_r;
   logic              halt_r, redirect_r;
   logic [NUM_WB-1:0] wb_vld_s;
   logic              st_vld_s, alloc_go_s, commit_go_s, flush_s;
   rob_entry_t        head_e_s;
   logic              ent_hit_s [DEPTH];
   logic              ent_st_s  [DEPTH];
   logic              ent_mis_s [DEPTH];
   logic [31:0]       ent_val_s [DEPTH];
   logic [31:0]       ent_tgt_s [DEPTH];
   logic [31:0]       ent_addr_s[DEPTH];
   logic              rd_hit_s  [NUM_RD];
   logic [31:0]       rd_val_s  [NUM_RD];

   // Offset from head modulo DEPTH must fall below the occupancy to be live
   function automatic logic in_win(input logic [IDX_W-1:0] idx, input logic [IDX_W-1:0] hd,
                                   input logic [IDX_W:0] cnt);
      logic [IDX_W-1:0] off;
      off = idx - hd;
      return ({1'b0, off} < cnt);
   endfunction

   assign head_e_s        = entries_r[head_r[IDX_W-1:0]];
   assign bus.alloc_ready = (count_r != FULL_CNT) && !redirect_r && !halt_r;
   assign alloc_go_s      = bus.alloc_valid && bus.alloc_ready;
   assign commit_go_s     = (count_r != '0) && head_e_s.ready && !halt_r;
   assign flush_s         = commit_go_s && head_e_s.mispred && is_ctrl(head_e_s.rtype);
   assign bus.alloc_idx   = tail_r[IDX_W-1:0];
   assign bus.count       = count_r;
   assign bus.empty       = (count_r == '0);
   assign bus.full        = (count_r == FULL_CNT);
   assign bus.halt        = halt_r;
   assign bus.redirect_valid = redirect_r;

   // Drop strobes during a redirect or aimed outside the occupied window
   always_comb begin
      wb_vld_s = '0;
      for (int p = 0; p < NUM_WB; p++) begin
         wb_vld_s[p] = bus.wb_valid[p] && !redirect_r &&
                       in_win(bus.wb_idx[p*IDX_W +: IDX_W], head_r[IDX_W-1:0], count_r);
      end
      st_vld_s = bus.st_valid && !redirect_r && in_win(bus.st_idx, head_r[IDX_W-1:0], count_r);
   end

   for (genvar e = 0; e < DEPTH; e++) begin : g_ent
      rob_wb_merge #(.IDX_W(IDX_W), .NUM_WB(NUM_WB)) u_merge (
         .q_idx(IDX_W'(e)), .wb_valid(wb_vld_s), .wb_idx(bus.wb_idx), .wb_data(bus.wb_data),
         .wb_mispred(bus.wb_mispred), .wb_target(bus.wb_target), .st_valid(st_vld_s),
         .st_idx(bus.st_idx), .st_addr(bus.st_addr), .st_data(bus.st_data),
         .hit(ent_hit_s[e]), .is_st(ent_st_s[e]), .value(ent_val_s[e]),
         .mispred(ent_mis_s[e]), .target(ent_tgt_s[e]), .addr(ent_addr_s[e])
      );
   end

   for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
      rob_wb_merge #(.IDX_W(IDX_W), .NUM_WB(NUM_WB)) u_fwd (
         .q_idx(bus.rd_idx[r*IDX_W +: IDX_W]), .wb_valid(wb_vld_s), .wb_idx(bus.wb_idx),
         .wb_data(bus.wb_data), .wb_mispred(bus.wb_mispred), .wb_target(bus.wb_target),
         .st_valid(st_vld_s), .st_idx(bus.st_idx), .st_addr(bus.st_addr), .st_data(bus.st_data),
         .hit(rd_hit_s[r]), .is_st(), .value(rd_val_s[r]), .mispred(), .target(), .addr()
      );
   end

   // Operand lookup with same-cycle forwarding
   always_comb begin
      bus.rd_data  = '0;
      bus.rd_ready = '0;
      for (int r = 0; r < NUM_RD; r++) begin
         bus.rd_data[r*32 +: 32] = rd_hit_s[r] ? rd_val_s[r]
                                               : entries_r[bus.rd_idx[r*IDX_W +: IDX_W]].value;
         bus.rd_ready[r] = rd_hit_s[r] || entries_r[bus.rd_idx[r*IDX_W +: IDX_W]].ready;
      end
   end

   // Pointers, occupancy and the registered commit strobes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_r <= '0; tail_r <= '0; count_r <= '0;
         halt_r <= 1'b0; redirect_r <= 1'b0;
         bus.commit_valid <= 1'b0; bus.commit_idx <= '0;
         bus.reg_we <= 1'b0; bus.reg_idx <= 5'd0; bus.reg_data <= 32'h0;
         bus.mem_we <= 1'b0; bus.mem_addr <= 32'h0; bus.mem_data <= 32'h0;
         bus.mem_size <= 3'b000; bus.redirect_pc <= 32'h0;
      end else begin
         bus.commit_valid <= commit_go_s;
         bus.commit_idx   <= head_r[IDX_W-1:0];
         bus.reg_we       <= commit_go_s && writes_rd(head_e_s.rtype) && (head_e_s.dest != 5'd0);
         bus.reg_idx      <= head_e_s.dest;
         bus.reg_data     <= head_e_s.value;
         bus.mem_we       <= commit_go_s && (head_e_s.rtype == ROB_STORE);
         bus.mem_addr     <= head_e_s.addr;
         bus.mem_data     <= head_e_s.value;
         bus.mem_size     <= F3_SW;
         redirect_r       <= flush_s;
         bus.redirect_pc  <= head_e_s.target;
         halt_r           <= halt_r || (commit_go_s && (head_e_s.rtype == ROB_HALT));
         if (flush_s) begin
            head_r <= '0; tail_r <= '0; count_r <= '0;
         end else begin
            head_r <= head_r + {{IDX_W{1'b0}}, commit_go_s};
            tail_r <= tail_r + {{IDX_W{1'b0}}, alloc_go_s};
            if (alloc_go_s && !commit_go_s) count_r <= count_r + (IDX_W+1)'(1);
            else if (!alloc_go_s && commit_go_s) count_r <= count_r - (IDX_W+1)'(1);
            else count_r <= count_r;
         end
      end
   end

   // Entry storage: allocation, writeback merge and flush
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int e = 0; e < DEPTH; e++) entries_r[e] <= '0;
      end else if (flush_s) begin
         for (int e = 0; e < DEPTH; e++) entries_r[e].ready <= 1'b0;
      end else begin
         for (int e = 0; e < DEPTH; e++) begin
            if (ent_hit_s[e]) begin
               entries_r[e].value   <= ent_val_s[e];
               entries_r[e].ready   <= 1'b1;
               entries_r[e].mispred <= ent_mis_s[e];
               entries_r[e].target  <= ent_st_s[e] ? entries_r[e].target : ent_tgt_s[e];
               entries_r[e].addr    <= ent_st_s[e] ? ent_addr_s[e] : entries_r[e].addr;
            end
         end
         if (alloc_go_s) begin
            entries_r[tail_r[IDX_W-1:0]] <= '{rtype: bus.alloc_type, dest: bus.alloc_dest,
               pc: bus.alloc_pc, value: 32'h0, addr: 32'h0, target: 32'h0,
               ready: (bus.alloc_type == ROB_HALT), mispred: 1'b0};
         end
      end
   end
endmodule

// File: tb/tb_rob_param.sv
// Scoreboard bench for rob_param: expected commits are queued at issue time
// and compared by a monitor whenever the ROB retires an entry.
module tb_rob_param;
   import rob_pkg::*;

   localparam int DEPTH = 16, IDX_W = 4, NUM_WB = 2, NUM_RD = 4;

   typedef struct {
      logic [3:0]  idx;
      logic        reg_we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        mem_we;
      logic [31:0] addr;
      logic        redir;
      logic [31:0] pc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0, n_errs = 0, redirect_cnt = 0, mem_cnt = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   rob_param_if #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_WB(NUM_WB), .NUM_RD(NUM_RD)) bus();
   rob_param #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_WB(NUM_WB), .NUM_RD(NUM_RD)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.alloc_valid = 1'b0; bus.alloc_type = ROB_ALU; bus.alloc_dest = 5'd0; bus.alloc_pc = 32'h0;
      bus.wb_valid = '0; bus.wb_idx = '0; bus.wb_data = '0; bus.wb_mispred = '0; bus.wb_target = '0;
      bus.st_valid = 1'b0; bus.st_idx = '0; bus.st_addr = 32'h0; bus.st_data = 32'h0;
      bus.rd_idx = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      sb.delete();
   endtask

   task automatic push_exp(input logic [3:0] idx, input logic reg_we, input logic [4:0] rd,
                           input logic [31:0] data, input logic mem_we, input logic [31:0] addr,
                           input logic redir, input logic [31:0] pc);
      exp_t e;
      e.idx = idx; e.reg_we = reg_we; e.rd = rd; e.data = data;
      e.mem_we = mem_we; e.addr = addr; e.redir = redir; e.pc = pc;
      sb.push_back(e);
   endtask

   task automatic alloc_cycle(input rob_type_t t, input logic [4:0] d, input logic [31:0] pc,
                              input logic [3:0] exp_idx);
      bus.alloc_valid = 1'b1; bus.alloc_type = t; bus.alloc_dest = d; bus.alloc_pc = pc;
      @(negedge clk);
      chk("alloc_idx", bus.alloc_idx, exp_idx);
      chk("alloc_ready", bus.alloc_ready, 1);
      tick();
      bus.alloc_valid = 1'b0;
   endtask

   task automatic set_wb(input int p, input logic [3:0] idx, input logic [31:0] data,
                         input logic mis, input logic [31:0] tgt);
      bus.wb_valid[p] = 1'b1;
      bus.wb_idx[p*IDX_W +: IDX_W] = idx;
      bus.wb_data[p*32 +: 32] = data;
      bus.wb_mispred[p] = mis;
      bus.wb_target[p*32 +: 32] = tgt;
   endtask

   // Commit monitor: every retirement must match the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.redirect_valid) redirect_cnt++;
         if (bus.mem_we) mem_cnt++;
         if (bus.commit_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_commit", {28'h0, bus.commit_idx}, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("commit_idx", bus.commit_idx, e.idx);
               chk("reg_we", bus.reg_we, e.reg_we);
               if (e.reg_we) begin
                  chk("reg_idx", bus.reg_idx, e.rd);
                  chk("reg_data", bus.reg_data, e.data);
               end
               chk("mem_we", bus.mem_we, e.mem_we);
               if (e.mem_we) begin
                  chk("mem_addr", bus.mem_addr, e.addr);
                  chk("mem_data", bus.mem_data, e.data);
                  chk("mem_size", bus.mem_size, 3'b010);
               end
               chk("redirect_valid", bus.redirect_valid, e.redir);
               if (e.redir) chk("redirect_pc", bus.redirect_pc, e.pc);
            end
         end else begin
            chk("idle_strobes", {bus.reg_we, bus.mem_we, bus.redirect_valid}, 3'b000);
         end
      end
   end

   initial begin
      clear_inputs();
      do_reset();

      // Reset state
      @(negedge clk);
      chk("rst_count", bus.count, 0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_full", bus.full, 0);
      chk("rst_alloc_ready", bus.alloc_ready, 1);
      chk("rst_halt", bus.halt, 0);
      chk("rst_commit", {bus.commit_valid, bus.reg_we, bus.mem_we, bus.redirect_valid}, 4'b0000);
      tick();

      // Fill to 16 without commits
      for (int i = 0; i < DEPTH; i++) begin
         push_exp(4'(i), 1'b1, 5'd1, 32'h5 + 32'(i), 1'b0, 32'h0, 1'b0, 32'h0);
         alloc_cycle(ROB_ALU, 5'd1, 32'h1000 + 32'(i*4), 4'(i));
      end
      @(negedge clk);
      chk("fill_full", bus.full, 1);
      chk("fill_alloc_ready", bus.alloc_ready, 0);
      chk("fill_count", bus.count, 16);
      tick();

      // Full: writeback head, then alloc alongside the commit is refused
      set_wb(0, 4'd0, 32'h5, 1'b0, 32'h0);
      tick();
      clear_inputs();
      bus.alloc_valid = 1'b1; bus.alloc_type = ROB_ALU; bus.alloc_dest = 5'd2;
      @(negedge clk);
      chk("full_alloc_ready", bus.alloc_ready, 0);
      tick();
      bus.alloc_valid = 1'b0;
      @(negedge clk);
      chk("after_commit_count", bus.count, 15);
      chk("after_commit_full", bus.full, 0);
      tick();

      // Wrap-around: 40 alloc/wb/commit triples
      do_reset();
      for (int k = 0; k < 40; k++) begin
         logic [4:0] d;
         d = (k % 5 == 0) ? 5'd0 : 5'd3;
         push_exp(4'(k % 16), d != 5'd0, d, 32'h1000 + 32'(k), 1'b0, 32'h0, 1'b0, 32'h0);
         alloc_cycle(ROB_ALU, d, 32'h2000 + 32'(k*4), 4'(k % 16));
         set_wb(k % 2, 4'(k % 16), 32'h1000 + 32'(k), 1'b0, 32'h0);
         tick();
         clear_inputs();
         tick();
      end
      repeat (3) tick();
      chk("wrap_drain", sb.size(), 0);
      chk("wrap_count", bus.count, 0);

      // Mispredicted branch at idx 2 with ready younger entries
      do_reset();
      redirect_cnt = 0;
      push_exp(4'd0, 1'b1, 5'd4, 32'hA0, 1'b0, 32'h0, 1'b0, 32'h0);
      push_exp(4'd1, 1'b1, 5'd5, 32'hA1, 1'b0, 32'h0, 1'b0, 32'h0);
      push_exp(4'd2, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h100);
      alloc_cycle(ROB_ALU, 5'd4, 32'h40, 4'd0);
      alloc_cycle(ROB_ALU, 5'd5, 32'h44, 4'd1);
      alloc_cycle(ROB_BRANCH, 5'd0, 32'h48, 4'd2);
      for (int i = 3; i < 6; i++) alloc_cycle(ROB_ALU, 5'(i + 3), 32'h40 + 32'(i*4), 4'(i));
      set_wb(0, 4'd0, 32'hA0, 1'b0, 32'h0); set_wb(1, 4'd1, 32'hA1, 1'b0, 32'h0);
      tick();
      set_wb(0, 4'd3, 32'hA3, 1'b0, 32'h0); set_wb(1, 4'd4, 32'hA4, 1'b0, 32'h0);
      tick();
      set_wb(0, 4'd5, 32'hA5, 1'b0, 32'h0); set_wb(1, 4'd2, 32'h0, 1'b1, 32'h100);
      tick();
      clear_inputs();
      tick();
      @(negedge clk);
      chk("flush_count", bus.count, 0);
      chk("flush_empty", bus.empty, 1);
      chk("flush_alloc_ready", bus.alloc_ready, 0);
      repeat (5) tick();
      chk("redirect_once", redirect_cnt, 1);
      chk("flush_drain", sb.size(), 0);
      alloc_cycle(ROB_ALU, 5'd1, 32'h100, 4'd0);

      // Out-of-order writeback with same-cycle lookup forwarding
      do_reset();
      push_exp(4'd0, 1'b1, 5'd9,  32'hC0, 1'b0, 32'h0, 1'b0, 32'h0);
      push_exp(4'd1, 1'b1, 5'd10, 32'hC1, 1'b0, 32'h0, 1'b0, 32'h0);
      push_exp(4'd2, 1'b1, 5'd11, 32'hC2, 1'b0, 32'h0, 1'b0, 32'h0);
      alloc_cycle(ROB_ALU, 5'd9,  32'h0, 4'd0);
      alloc_cycle(ROB_ALU, 5'd10, 32'h4, 4'd1);
      alloc_cycle(ROB_ALU, 5'd11, 32'h8, 4'd2);
      set_wb(0, 4'd2, 32'hC2, 1'b0, 32'h0); set_wb(1, 4'd0, 32'hC0, 1'b0, 32'h0);
      bus.rd_idx[0*IDX_W +: IDX_W] = 4'd2;
      bus.rd_idx[1*IDX_W +: IDX_W] = 4'd1;
      @(negedge clk);
      chk("fwd_ready2", bus.rd_ready[0], 1);
      chk("fwd_data2", bus.rd_data[0 +: 32], 32'hC2);
      chk("lookup_notready1", bus.rd_ready[1], 0);
      tick();
      clear_inputs();
      set_wb(0, 4'd1, 32'hDEAD, 1'b0, 32'h0); set_wb(1, 4'd1, 32'hC1, 1'b0, 32'h0);
      bus.rd_idx[0*IDX_W +: IDX_W] = 4'd2;
      bus.rd_idx[1*IDX_W +: IDX_W] = 4'd1;
      @(negedge clk);
      chk("fwd_prio_data1", bus.rd_data[32 +: 32], 32'hC1);
      chk("fwd_prio_ready1", bus.rd_ready[1], 1);
      chk("stored_data2", bus.rd_data[0 +: 32], 32'hC2);
      tick();
      clear_inputs();
      repeat (5) tick();
      chk("ooo_drain", sb.size(), 0);

      // Store then HALT; halt is sticky until reset
      do_reset();
      mem_cnt = 0;
      push_exp(4'd0, 1'b0, 5'd0, 32'hAB, 1'b1, 32'h40, 1'b0, 32'h0);
      push_exp(4'd1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      alloc_cycle(ROB_STORE, 5'd0, 32'h10, 4'd0);
      alloc_cycle(ROB_HALT, 5'd0, 32'h14, 4'd1);
      bus.st_valid = 1'b1; bus.st_idx = 4'd0; bus.st_addr = 32'h40; bus.st_data = 32'hAB;
      tick();
      clear_inputs();
      repeat (5) tick();
      @(negedge clk);
      chk("halt_set", bus.halt, 1);
      chk("halt_alloc_ready", bus.alloc_ready, 0);
      chk("store_once", mem_cnt, 1);
      chk("halt_drain", sb.size(), 0);
      bus.alloc_valid = 1'b1; bus.alloc_type = ROB_ALU; bus.alloc_dest = 5'd1;
      tick();
      bus.alloc_valid = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      chk("halt_sticky", bus.halt, 1);
      chk("halt_no_alloc", bus.count, 0);
      rst_n = 1'b0;
      tick();
      @(negedge clk);
      chk("reset_halt", bus.halt, 0);
      chk("reset_count", bus.count, 0);
      chk("reset_alloc_ready", bus.alloc_ready, 1);
      chk("reset_strobes", {bus.commit_valid, bus.mem_we, bus.reg_we}, 3'b000);
      rst_n = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end
endmodule

// File: doc/rob_param.md
Name: rob_param

Overview:
- Parametrised in-order-commit reorder buffer for the out-of-order RV32I core.
- Sits between issue/rename, the execution units (NUM_WB result ports plus one store port) and architectural state: register file, rename status table, data memory and PC redirect.
- Adds five things to the current ROB: configurable depth, N writeback ports, valid/ready allocation, branch-mispredict flush and synchronous reset.

Parameters:
DEPTH, 16, number of entries; power of two, >= 2
IDX_W, $clog2(DEPTH), entry index width
NUM_WB, 2, number of CDB writeback ports
NUM_RD, 4, number of operand lookup ports

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
alloc_valid  in  1  issue requests an entry
alloc_ready  out  1  entry available this cycle
alloc_type  in  3  rob_type_t: ALU, LOAD, STORE, BRANCH, JAL, HALT
alloc_dest  in  5  destination architectural register
alloc_pc  in  32  instruction PC
alloc_idx  out  IDX_W  index granted; equals the tail pointer
wb_valid  in  NUM_WB  per-port result strobe
wb_idx  in  NUM_WB*IDX_W  target entry
wb_data  in  NUM_WB*32  result value
wb_mispred  in  NUM_WB  branch/JAL resolved as mispredicted
wb_target  in  NUM_WB*32  correct next PC when mispredicted
st_valid  in  1  store address/data resolved
st_idx  in  IDX_W  store entry
st_addr  in  32  store address
st_data  in  32  store data
rd_idx  in  NUM_RD*IDX_W  operand lookup index
rd_data  out  NUM_RD*32  entry value
rd_ready  out  NUM_RD  entry completed
commit_valid  out  1  head retired this cycle
commit_idx  out  IDX_W  retired index, used to clear rename status
reg_we  out  1  register file write
reg_idx  out  5  register file write index
reg_data  out  32  register file write data
mem_we  out  1  store commit
mem_addr  out  32  store commit address
mem_data  out  32  store commit data
mem_size  out  3  store funct3
redirect_valid  out  1  flush and refetch
redirect_pc  out  32  refetch PC
halt  out  1  sticky end-of-program
count  out  IDX_W+1  occupied entries
empty  out  1  count == 0
full  out  1  count == DEPTH

Behaviour:
- Pointers:
  - head and tail are IDX_W+1 bits; the low bits index the entry, and the MSB distinguishes full from empty.
  - Wrap-around is natural modulo 2*DEPTH.
- Reset (rst_n low at a clk edge):
  - head, tail, count = 0; all ready bits and halt cleared.
  - Every commit/strobe output is 0; alloc_ready is 1 in the first cycle after reset.
- Allocation:
  - An entry is allocated when alloc_valid && alloc_ready at the edge.
  - The entry records type, dest, pc and mispred = 0, with ready = 1 for HALT and ready = 0 otherwise; tail then increments.
  - alloc_ready = !full && !redirect_valid && !halt.
  - There is no same-cycle pass-through: when full, a simultaneous commit does not enable allocation.
- Writeback:
  - Each wb port with a valid strobe writes value, mispred and target, and sets ready at the edge.
  - st_valid writes addr, data and ready.
  - Strobes whose index falls outside the occupied window are ignored.
  - Two ports hitting the same index is illegal; if it happens, the higher-numbered port wins.
- Lookup:
  - Combinational. A same-cycle wb/st strobe to the same index forwards its data and ready = 1.
  - The highest-numbered matching port wins.
- Commit (at most one per cycle):
  - Commit happens when !empty && ready[head] && !halt, using the registered ready bit. Earliest commit is the edge after writeback.
  - All outputs below are registered and valid in the cycle after the commit decision.
  - ALU/LOAD/JAL: reg_we = 1 when dest != 0; reg_data = value.
  - STORE: mem_we = 1 with addr, data and size.
  - BRANCH: no architectural write.
  - HALT: halt set and sticky; no further commits.
  - Mispredicted BRANCH/JAL: redirect_valid = 1, redirect_pc = target.
    - In the same cycle, all entries are flushed: head = tail = 0, count = 0, all ready bits cleared.
    - While redirect_valid is high, allocation and strobes are dropped.
- count tracks +alloc and -commit; simultaneous alloc and commit leaves count unchanged. Flush overrides both.
- Reset mid-operation discards everything, including a pending redirect.

Decomposition:
- Package rob_pkg holds:
  - rob_type_t enum.
  - RV32 opcode/funct3 constants.
  - The rob_entry_t struct: type, dest, pc, value, addr, target, ready, mispred.
- One sub-module, rob_wb_merge: priority-merges the NUM_WB+1 strobes per index. It is shared by the entry-write and lookup-forward paths.

Test Plan:
- Reset, then 16 ALU allocs with no commit -> full = 1 and alloc_ready = 0 after the 16th; alloc_idx sequence is 0..15; count = 16.
- Fill to 16, writeback idx 0 with 0x5, then alloc and commit together -> reg_we with reg_data 0x5; alloc is refused that cycle; count = 15.
- Wrap-around: 40 alloc/wb/commit triples with dest x3 -> alloc_idx wraps 15 to 0; commits stay in program order; x0 dest never raises reg_we.
- Branch at idx 2 (wb_mispred = 1, target 0x100), younger idx 3..5 ready -> a single redirect to 0x100; no commits from idx 3..5; count = 0; empty = 1.
- Out-of-order wb (idx 2 before idx 0, both ports in the same cycle) plus lookup on idx 2 -> rd_ready forwarded the same cycle; commit order is 0,1,2.
- STORE at idx 0 (st_addr 0x40, st_data 0xAB, size SW), then HALT -> mem_we once with those values; halt stays at 1; rst_n low then clears everything.
